// File: rtl/banked_mem_arb.sv
// Shared word-addressed memory split into even/odd banks so that SINGLE or DOUBLE
// accesses at any address complete in one cycle. One writer and NUM_RD arbitrated readers.
module banked_mem_arb #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 1024,
    parameter int NUM_RD   = 2,
    parameter int READ_LAT = 2,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_req,
    output logic                         wr_gnt,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic                         wr_width,
    input  logic [2*DATA_W-1:0]          wr_data,
    input  logic [NUM_RD-1:0]            rd_req,
    output logic [NUM_RD-1:0]            rd_gnt,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    input  logic [NUM_RD-1:0]            rd_width,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD*2*DATA_W-1:0]   rd_data
);

    localparam int ROWS  = DEPTH / 2;
    localparam int ROW_W = ADDR_W - 1;
    localparam int CH_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    typedef struct packed {
        logic                valid;
        logic [CH_W-1:0]     ch;
        logic [2*DATA_W-1:0] data;
    } rd_pkt_t;

    logic [DATA_W-1:0] bank0_q [ROWS];
    logic [DATA_W-1:0] bank1_q [ROWS];

    logic [CH_W-1:0] rr_ptr_q;
    logic [CH_W-1:0] rr_ptr_d;

    logic            gnt_any;
    logic [CH_W-1:0] gnt_idx;
    logic            hi_hit;
    logic [CH_W-1:0] hi_idx;
    logic            lo_hit;
    logic [CH_W-1:0] lo_idx;

    // Round-robin: lowest requester at or above the pointer, else lowest overall.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_hit = 1'b0;
        lo_idx = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (rd_req[i]) begin
                lo_hit = 1'b1;
                lo_idx = CH_W'(i);
                if (CH_W'(i) >= rr_ptr_q) begin
                    hi_hit = 1'b1;
                    hi_idx = CH_W'(i);
                end
            end
        end
        gnt_any = !rst && !wr_req && lo_hit;
        gnt_idx = hi_hit ? hi_idx : lo_idx;
    end

    assign wr_gnt = wr_req && !rst;
    assign rd_gnt = gnt_any ? (NUM_RD'(1) << gnt_idx) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == CH_W'(NUM_RD - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    logic [ROW_W-1:0] wr_row;
    logic [ROW_W-1:0] wr_row_p1;

    assign wr_row    = wr_addr[ADDR_W-1:1];
    assign wr_row_p1 = wr_row + ROW_W'(1);

    // An odd DOUBLE places its high word in the next even row; the row counter wraps at the top.
    always_ff @(posedge clk) begin
        if (wr_gnt) begin
            if (!wr_addr[0]) begin
                bank0_q[wr_row] <= wr_data[DATA_W-1:0];
                if (wr_width) begin
                    bank1_q[wr_row] <= wr_data[2*DATA_W-1:DATA_W];
                end
            end else begin
                bank1_q[wr_row] <= wr_data[DATA_W-1:0];
                if (wr_width) begin
                    bank0_q[wr_row_p1] <= wr_data[2*DATA_W-1:DATA_W];
                end
            end
        end
    end

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_width;
    logic [ROW_W-1:0]  rd_row;
    logic [ROW_W-1:0]  rd_row_p1;
    logic [DATA_W-1:0] rd_lo;
    logic [DATA_W-1:0] rd_hi;
    rd_pkt_t           head;
    rd_pkt_t           tail;

    always_comb begin
        sel_addr  = '0;
        sel_width = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (CH_W'(i) == gnt_idx) begin
                sel_addr  = rd_addr[i*ADDR_W +: ADDR_W];
                sel_width = rd_width[i];
            end
        end
    end

    assign rd_row    = sel_addr[ADDR_W-1:1];
    assign rd_row_p1 = rd_row + ROW_W'(1);

    always_comb begin
        if (!sel_addr[0]) begin
            rd_lo = bank0_q[rd_row];
            rd_hi = bank1_q[rd_row];
        end else begin
            rd_lo = bank1_q[rd_row];
            rd_hi = bank0_q[rd_row_p1];
        end
        head.valid = gnt_any;
        head.ch    = gnt_idx;
        head.data  = sel_width ? {rd_hi, rd_lo} : {{DATA_W{1'b0}}, rd_lo};
    end

    // The output register is the last latency stage, so only READ_LAT-1 stages sit in between.
    if (READ_LAT == 1) begin : g_nopipe
        assign tail = head;
    end else begin : g_pipe
        rd_pkt_t pipe_q [READ_LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < READ_LAT - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= head;
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign tail = pipe_q[READ_LAT-2];
    end

    logic [NUM_RD-1:0]   rd_valid_q;
    logic [2*DATA_W-1:0] rd_data_q [NUM_RD];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= '0;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_valid_q[i] <= tail.valid && (tail.ch == CH_W'(i));
                if (tail.valid && (tail.ch == CH_W'(i))) begin
                    rd_data_q[i] <= tail.data;
                end
            end
        end
    end

    assign rd_valid = rd_valid_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_data
        assign rd_data[g*2*DATA_W +: 2*DATA_W] = rd_data_q[g];
    end

endmodule
